muxadd_sel_ctrl: RTL

MUXADD_SEL_CTRL -- requirements
Module: muxadd_sel_ctrl

---
 rtl/muxadd_pkg.sv | 29 ++
 rtl/lfsr8.sv | 53 +++++
 rtl/muxadd_sel_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/muxadd_pkg.sv
// -----------------------------------------------------------------------------
// muxadd_pkg
//   Shared definitions for the mux-adder select controller: select-policy and
//   FSM state encodings, default mux geometry and the LFSR feedback taps.
// -----------------------------------------------------------------------------
package muxadd_pkg;

    localparam int DEF_INUM    = 8;
    localparam int DEF_LOGINUM = 3;

    // Feedback taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci LFSR:
    // the polynomial terms 8,6,5,4 map to state bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS  = 8'hB8;
    localparam logic [7:0] LFSR_RESET = 8'h01;

    typedef enum logic [1:0] {
        MODE_RR     = 2'd0,
        MODE_LFSR   = 2'd1,
        MODE_MASK   = 2'd2,
        MODE_RR_ALT = 2'd3   // behaves exactly like MODE_RR
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr8.sv
// -----------------------------------------------------------------------------
// lfsr8
//   8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1. Shifts left; the new
//   bit 0 is the XOR of the tapped bits. A zero seed would lock the register,
//   so it is replaced by 8'h01 on load.
//
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (state -> 8'h01)
//   load    in   load seed this cycle (wins over advance)
//   seed    in   [7:0] value loaded on load
//   advance in   step the sequence once this cycle
//   state   out  [7:0] current register contents
// -----------------------------------------------------------------------------
module lfsr8
    import muxadd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic [7:0] state_d;
    logic       feedback;

    always_comb begin
        // NOTE: every variable gets a default at the top of a combinational
        // block so no path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        feedback = ^(state_q & LFSR_TAPS);
        if (load) begin
            state_d = (seed == 8'h00) ? LFSR_RESET : seed;
        end else if (advance) begin
            state_d = {state_q[6:0], feedback};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same edge, independent of block order.
        if (!rst_n) begin
            state_q <= LFSR_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/muxadd_sel_ctrl.sv
// -----------------------------------------------------------------------------
// muxadd_sel_ctrl
//   Generates a stream of mux-adder select values. A start in IDLE captures
//   the configuration; the following cycles each produce one valid select
//   according to the chosen policy (round-robin, LFSR, masked round-robin).
//   After len valid cycles a one-cycle done pulse is issued. All outputs are
//   registered.
//
//   Parameters: INUM (mux inputs), LOGINUM (= log2(INUM)), CNTW (length width)
//
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin one stream (only honoured in IDLE)
//   abort     in   drop the current stream at the next edge, no done pulse
//   cfg_mode  in   [1:0] 0 RR, 1 LFSR, 2 masked RR, 3 as 0
//   cfg_mask  in   [INUM-1:0] eligible inputs for masked RR
//   cfg_len   in   [CNTW-1:0] valid cycles per stream, 0 means 2^CNTW
//   cfg_seed  in   [7:0] LFSR seed
//   sel       out  [LOGINUM-1:0] mux select, held while sel_vld=0
//   sel_vld   out  sel belongs to a stream cycle
//   busy      out  FSM not in IDLE
//   done      out  one-cycle pulse following the last valid cycle
//   err       out  one-cycle pulse for a rejected start (masked RR, mask 0)
// -----------------------------------------------------------------------------
module muxadd_sel_ctrl
    import muxadd_pkg::*;
#(
    parameter int INUM    = DEF_INUM,
    parameter int LOGINUM = DEF_LOGINUM,
    parameter int CNTW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_mode,
    input  logic [INUM-1:0]    cfg_mask,
    input  logic [CNTW-1:0]    cfg_len,
    input  logic [7:0]         cfg_seed,
    output logic [LOGINUM-1:0] sel,
    output logic               sel_vld,
    output logic               busy,
    output logic               done,
    output logic               err
);

    // Next set mask bit strictly above base, wrapping; returns base itself
    // when it is the only set bit. Index arithmetic wraps in LOGINUM bits,
    // which equals modulo INUM.
    function automatic logic [LOGINUM-1:0] next_masked(
        input logic [INUM-1:0]    mask,
        input logic [LOGINUM-1:0] base
    );
        logic [LOGINUM-1:0] res;
        logic [LOGINUM-1:0] idx;
        logic               hit;
        res = base;
        hit = 1'b0;
        for (int i = 1; i <= INUM; i++) begin
            idx = base + LOGINUM'(i);
            if (!hit && mask[idx]) begin
                res = idx;
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [INUM-1:0]    mask_q, mask_d;
    logic [CNTW-1:0]    len_q, len_d;
    logic [CNTW-1:0]    count_q, count_d;
    logic [LOGINUM-1:0] sel_q, sel_d;
    logic               sel_vld_q, sel_vld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               lfsr_load;
    logic               lfsr_adv;
    logic [7:0]         lfsr_state;
    logic               unused_lfsr_hi;

    mode_e              cfg_mode_n;
    logic               start_rej;
    logic               start_ok;
    logic               first_cycle;
    logic               last_cycle;

    lfsr8 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .seed    (cfg_seed),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    // Only the low bits select an input; the rest just carry the sequence.
    assign unused_lfsr_hi = ^lfsr_state[7:LOGINUM];

    // Mode 3 is folded onto round-robin when captured, so the datapath only
    // ever sees three policies.
    assign cfg_mode_n = (cfg_mode == MODE_RR_ALT) ? MODE_RR : mode_e'(cfg_mode);

    assign start_rej  = (state_q == ST_IDLE) && start && !abort &&
                        (cfg_mode_n == MODE_MASK) && (cfg_mask == '0);
    assign start_ok   = (state_q == ST_IDLE) && start && !abort && !start_rej;

    // The count never returns to 0 inside a stream (even for len 0 it stops
    // at 2^CNTW-1), so count 0 identifies the first valid cycle.
    assign first_cycle = (count_q == '0);
    assign last_cycle  = (count_q == len_q - CNTW'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok)   state_d = ST_RUN;
            ST_RUN:  if (last_cycle) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    // ---------------- output / datapath logic ----------------
    always_comb begin
        mode_d    = mode_q;
        mask_d    = mask_q;
        len_d     = len_q;
        count_d   = count_q;
        sel_d     = sel_q;
        sel_vld_d = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        busy_d    = (state_d != ST_IDLE);

        if (!abort) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_rej) begin
                        err_d = 1'b1;
                    end else if (start_ok) begin
                        mode_d    = cfg_mode_n;
                        mask_d    = cfg_mask;
                        len_d     = cfg_len;
                        count_d   = '0;
                        lfsr_load = 1'b1;
                    end
                end
                // ST_RUN covers the cycle that issues the last valid select
                // too; DONE then follows as the done-pulse cycle.
                ST_RUN: begin
                    sel_vld_d = 1'b1;
                    count_d   = count_q + CNTW'(1);
                    unique case (mode_q)
                        MODE_LFSR: begin
                            sel_d    = lfsr_state[LOGINUM-1:0];
                            lfsr_adv = 1'b1;
                        end
                        MODE_MASK: begin
                            // Seeding the search from the top index makes
                            // the first pick the lowest set bit.
                            sel_d = next_masked(mask_q, first_cycle ? '1 : sel_q);
                        end
                        default: begin
                            if (first_cycle || sel_q == LOGINUM'(INUM - 1)) begin
                                sel_d = '0;
                            end else begin
                                sel_d = sel_q + LOGINUM'(1);
                            end
                        end
                    endcase
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- datapath / output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= MODE_RR;
            mask_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            mask_q    <= mask_d;
            len_q     <= len_d;
            count_q   <= count_d;
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign sel     = sel_q;
    assign sel_vld = sel_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
